banked_page_buffer: RTL

// - Successor to the single-page buffer between the UFM sequential reader and random-access consumers (UART, SPI).
// - Fills pages of PAGE_DEPTH words from a strobe/ack sequential source; serves random reads from a completed page.
// - Width, depth and address span are parametrised.
// - Optional ping-pong mode fills the next page while the current one is read, so flush-to-ready latency is 1 cycle.
//

---
 rtl/banked_page_buffer_pkg.sv | 36 +++
 rtl/banked_page_mem.sv | 47 ++++
 rtl/banked_page_buffer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/banked_page_buffer_pkg.sv
// banked_page_buffer_pkg
//   Shared types and defaults for the banked page buffer.
//   - bank_state_t : per-bank life cycle EMPTY -> FILLING -> FULL -> EMPTY
//   - DEFAULT_*    : default parameter values for the top and the memory
//   - addr_width() : ceil(log2(depth)), never less than 1
//   Optional feature macro used by the top: BANKED_PAGE_BUFFER_PINGPONG_EN.
package banked_page_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  localparam int DEFAULT_DATA_W     = 8;
  localparam int DEFAULT_PAGE_DEPTH = 16;
  localparam int DEFAULT_SEQ_ADDR_W = 11;

  // Number of bank slots in the state array; only the first one is used
  // when ping-pong operation is compiled out.
  localparam int MAX_BANKS = 2;

  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < depth) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/banked_page_mem.sv
// banked_page_mem
//   One page of storage: DATA_W x DEPTH, synchronous write, registered read.
//   Written so it maps onto a block RAM with an output register.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset (read register only)
//     wr_en/wr_addr/wr_data   write port
//     rd_en/rd_addr           read request; rd_data updates on the next edge
//     rd_data                 registered read data, holds between reads
module banked_page_mem
  import banked_page_buffer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_PAGE_DEPTH,
  localparam int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Output register; only loads on a read so the value holds in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/banked_page_buffer.sv
// banked_page_buffer
//   Fills pages of PAGE_DEPTH words from a strobe/ack sequential source and
//   serves random reads from a completed page.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     seq__stb / seq__addr     word request towards the sequential source
//     seq__data / seq__ack     returned word, qualified by a one-cycle ack
//     rand__addr/read_en       random read request into the read page
//     rand__flush              release the read page
//     rand__data/valid         registered read data, one-cycle valid pulse
//     rand__page_ready         read page is FULL
//   Macro BANKED_PAGE_BUFFER_PINGPONG_EN: two banks, the next page fills while
//   the current one is read. Undefined: one bank, filling pauses while FULL.
module banked_page_buffer
  import banked_page_buffer_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int PAGE_DEPTH = DEFAULT_PAGE_DEPTH,
  parameter int SEQ_ADDR_W = DEFAULT_SEQ_ADDR_W,
  localparam int RAND_ADDR_W = addr_width(PAGE_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   seq__stb,
  output logic [SEQ_ADDR_W-1:0]  seq__addr,
  input  logic [DATA_W-1:0]      seq__data,
  input  logic                   seq__ack,
  input  logic [RAND_ADDR_W-1:0] rand__addr,
  input  logic                   rand__read_en,
  input  logic                   rand__flush,
  output logic [DATA_W-1:0]      rand__data,
  output logic                   rand__valid,
  output logic                   rand__page_ready
);

`ifdef BANKED_PAGE_BUFFER_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  bank_state_t            state_r [MAX_BANKS];
  bank_state_t            state_s [MAX_BANKS];
  logic [RAND_ADDR_W-1:0] idx_r, idx_s;
  logic [SEQ_ADDR_W-1:0]  base_r, base_s;
  logic                   wr_bank_r, wr_bank_s;
  logic                   rd_bank_r, rd_bank_s;
  logic                   stb_r, stb_s;
  logic [SEQ_ADDR_W-1:0]  addr_r;
  logic                   valid_r;
  logic                   ready_r, ready_s;
  logic                   rd_sel_r;

  logic                   ack_ok_s;
  logic                   flush_ok_s;
  logic                   read_ok_s;
  logic                   last_word_s;
  logic [DATA_W-1:0]      bank_rd_data_s [MAX_BANKS];

  // An ack only counts while a request is outstanding; stale acks fall away.
  assign ack_ok_s    = seq__ack & stb_r;
  assign flush_ok_s  = rand__flush & (state_r[rd_bank_r] == FULL);
  // Flush has priority over a read in the same cycle; reads are spaced by
  // the valid pulse so at most one is in flight.
  assign read_ok_s   = rand__read_en & (state_r[rd_bank_r] == FULL) & ~valid_r & ~rand__flush;
  assign last_word_s = (idx_r == RAND_ADDR_W'(PAGE_DEPTH - 1));

  // Next state of the bank FSMs, fill counters and bank pointers.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    base_s    = base_r;
    wr_bank_s = wr_bank_r;
    rd_bank_s = rd_bank_r;

    if (ack_ok_s) begin
      if (last_word_s) begin
        state_s[wr_bank_r] = FULL;
        idx_s              = {RAND_ADDR_W{1'b0}};
        base_s             = base_r + SEQ_ADDR_W'(PAGE_DEPTH);
`ifdef BANKED_PAGE_BUFFER_PINGPONG_EN
        wr_bank_s          = ~wr_bank_r;
`else
        wr_bank_s          = wr_bank_r;
`endif
      end else begin
        idx_s = idx_r + RAND_ADDR_W'(1);
      end
    end else if (state_r[wr_bank_r] == EMPTY) begin
      state_s[wr_bank_r] = FILLING;
    end else begin
      state_s[wr_bank_r] = state_r[wr_bank_r];
    end

    // The flushed bank is always FULL, so it never collides with the
    // fill-side transition above, which only touches EMPTY/FILLING banks.
    if (flush_ok_s) begin
      state_s[rd_bank_r] = EMPTY;
`ifdef BANKED_PAGE_BUFFER_PINGPONG_EN
      rd_bank_s          = ~rd_bank_r;
`else
      rd_bank_s          = rd_bank_r;
`endif
    end else begin
      rd_bank_s = rd_bank_r;
    end

    // The strobe drops for one cycle after each accepted ack.
    if (ack_ok_s) begin
      stb_s = 1'b0;
    end else begin
      stb_s = (state_s[wr_bank_s] == FILLING);
    end

    ready_s = (state_s[rd_bank_s] == FULL);
  end

  // Bank state, counters and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < MAX_BANKS; b++) begin
        state_r[b] <= EMPTY;
      end
      idx_r     <= {RAND_ADDR_W{1'b0}};
      base_r    <= {SEQ_ADDR_W{1'b0}};
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      base_r    <= base_s;
      wr_bank_r <= wr_bank_s;
      rd_bank_r <= rd_bank_s;
    end
  end

  // Registered outputs and the read-bank select for the data mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_r    <= 1'b0;
      addr_r   <= {SEQ_ADDR_W{1'b0}};
      valid_r  <= 1'b0;
      ready_r  <= 1'b0;
      rd_sel_r <= 1'b0;
    end else begin
      stb_r    <= stb_s;
      addr_r   <= base_s + SEQ_ADDR_W'(idx_s);
      valid_r  <= read_ok_s;
      ready_r  <= ready_s;
      rd_sel_r <= read_ok_s ? rd_bank_r : rd_sel_r;
    end
  end

  for (genvar b = 0; b < MAX_BANKS; b++) begin : g_bank
    if (b < NUM_BANKS) begin : g_mem
      banked_page_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (PAGE_DEPTH)
      ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ack_ok_s && (wr_bank_r == 1'(b))),
        .wr_addr (idx_r),
        .wr_data (seq__data),
        .rd_en   (read_ok_s && (rd_bank_r == 1'(b))),
        .rd_addr (rand__addr),
        .rd_data (bank_rd_data_s[b])
      );
    end else begin : g_none
      assign bank_rd_data_s[b] = {DATA_W{1'b0}};
    end
  end

  assign seq__stb         = stb_r;
  assign seq__addr        = addr_r;
  assign rand__data       = bank_rd_data_s[rd_sel_r];
  assign rand__valid      = valid_r;
  assign rand__page_ready = ready_r;

endmodule
